// File: rtl/run_sequencer_pkg.sv
// Shared types and constants for the benchmark run sequencer.
package run_sequencer_pkg;

  // Run controller states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RST     = 3'd1,
    RUN     = 3'd2,
    DONE    = 3'd3,
    TIMEOUT = 3'd4
  } run_state_t;

  // Program ROM select encodings for the mux above the cores.
  localparam logic [1:0] PROG_INT2FLOAT = 2'd0;
  localparam logic [1:0] PROG_FLOAT2INT = 2'd1;
  localparam logic [1:0] PROG_FLOATADD  = 2'd2;

  localparam int unsigned DEFAULT_MAX_CYCLES = 20000;

  // Reset-length counter width; covers RST_CYCLES up to 15.
  localparam int unsigned RST_CNT_W = 4;

endpackage

// File: rtl/run_sequencer_stall_detect.sv
// PC stall detector: counts consecutive RUN cycles with an unchanged PC and
// flags the cycle on which the count reaches STALL_LIMIT.
module stall_detect #(
  parameter int unsigned IW          = 8,
  parameter int unsigned STALL_LIMIT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [IW-1:0] pc,
  output logic          hit_c
);
  localparam int unsigned SW = $clog2(STALL_LIMIT + 1);

  logic [IW-1:0] prev_pc;
  logic [SW-1:0] stall_cnt;
  logic          same_c;

  assign same_c = (pc == prev_pc);

  // Track previous PC; count stalled cycles while enabled, saturating at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_pc   <= '0;
      stall_cnt <= '0;
    end else begin
      prev_pc <= pc;
      if (!en || !same_c) begin
        stall_cnt <= '0;
      end else if (stall_cnt != SW'(STALL_LIMIT)) begin
        stall_cnt <= stall_cnt + SW'(1);
      end
    end
  end

  assign hit_c = en && same_c && (stall_cnt == SW'(STALL_LIMIT - 1));

endmodule

// File: rtl/run_sequencer.sv
// Benchmark run sequencer: holds the CPU core in reset, releases it for one
// run, counts RUN cycles, and ends the run on done, timeout or abort.
// Optional: define HANG_DETECT_EN to build PC-stall hang detection.
module run_sequencer
  import run_sequencer_pkg::*;
#(
  parameter int unsigned RST_CYCLES  = 2,
  parameter int unsigned CW          = 16,
  parameter int unsigned MAX_CYCLES  = DEFAULT_MAX_CYCLES,
  parameter int unsigned IW          = 8,
  parameter int unsigned STALL_LIMIT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    prog_sel,
  input  logic          cpu_done,
  input  logic [IW-1:0] cpu_pc,
  output logic          cpu_reset,
  output logic [1:0]    prog_sel_q,
  output logic          busy,
  output logic          finished,
  output logic          timed_out,
  output logic          hung,
  output logic [CW-1:0] cycle_count
);

  run_state_t           state_q, state_d;
  logic [RST_CNT_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [CW-1:0]        cycle_count_d;
  logic [1:0]           prog_sel_d;
  logic                 cpu_reset_d;
  logic                 hung_d;
  logic                 stall_hit_c;

`ifdef HANG_DETECT_EN
  stall_detect #(
    .IW          (IW),
    .STALL_LIMIT (STALL_LIMIT)
  ) u_stall_detect (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == RUN),
    .pc    (cpu_pc),
    .hit_c (stall_hit_c)
  );
`else
  logic unused_cfg;
  assign unused_cfg  = ^{cpu_pc, 32'(STALL_LIMIT)};
  assign stall_hit_c = 1'b0;
`endif

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rst_cnt_q   <= '0;
      cycle_count <= '0;
      prog_sel_q  <= '0;
      cpu_reset   <= 1'b1;
      hung        <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      cycle_count <= cycle_count_d;
      prog_sel_q  <= prog_sel_d;
      cpu_reset   <= cpu_reset_d;
      hung        <= hung_d;
    end
  end

  // Next-state and next-output logic; abort beats start, done beats timeout.
  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    cycle_count_d = cycle_count;
    prog_sel_d    = prog_sel_q;
    hung_d        = hung;

    unique case (state_q)
      IDLE, DONE, TIMEOUT: begin
        if (start) begin
          prog_sel_d    = prog_sel;
          cycle_count_d = '0;
          hung_d        = 1'b0;
          rst_cnt_d     = RST_CNT_W'(RST_CYCLES - 1);
          state_d       = RST;
        end
      end
      RST: begin
        if (abort) begin
          state_d = IDLE;
        end else if (rst_cnt_q == '0) begin
          state_d = RUN;
        end else begin
          rst_cnt_d = rst_cnt_q - RST_CNT_W'(1);
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cpu_done) begin
          state_d = DONE;
        end else begin
          cycle_count_d = cycle_count + CW'(1);
          if ((cycle_count == CW'(MAX_CYCLES - 1)) || stall_hit_c) begin
            state_d = TIMEOUT;
          end
          hung_d = stall_hit_c;
        end
      end
      default: state_d = IDLE;
    endcase

    // Core runs in RUN and stays out of reset in DONE for post-run inspection.
    cpu_reset_d = !((state_d == RUN) || (state_d == DONE));
  end

  assign busy      = (state_q == RST) || (state_q == RUN);
  assign finished  = (state_q == DONE);
  assign timed_out = (state_q == TIMEOUT);

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer with a scoreboard of expected run results.
module tb_run_sequencer;

  localparam int unsigned CW = 16;
  localparam int unsigned IW = 8;

  typedef struct {
    logic          fin;
    logic          to;
    logic          hung;
    logic [CW-1:0] cc;
    logic          crst;
    logic [1:0]    ps;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, start, abort, cpu_done;
  logic [1:0]    prog_sel;
  logic [IW-1:0] cpu_pc;
  logic          cpu_reset, busy, finished, timed_out, hung;
  logic [1:0]    prog_sel_q;
  logic [CW-1:0] cycle_count;

  int   n_pass  = 0;
  int   n_total = 0;
  exp_t sb[$];

  run_sequencer #(
    .RST_CYCLES  (2),
    .CW          (CW),
    .MAX_CYCLES  (100),
    .IW          (IW),
    .STALL_LIMIT (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .prog_sel    (prog_sel),
    .cpu_done    (cpu_done),
    .cpu_pc      (cpu_pc),
    .cpu_reset   (cpu_reset),
    .prog_sel_q  (prog_sel_q),
    .busy        (busy),
    .finished    (finished),
    .timed_out   (timed_out),
    .hung        (hung),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // Start a run, step the stub core, and compare the outcome against the scoreboard.
  task automatic run_case(input string tag, input logic [1:0] ps, input int done_at,
                          input bit hold_pc, input bit poke, input exp_t e);
    int   k;
    bit   ended;
    exp_t x;
    sb.push_back(e);
    prog_sel = ps;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_cc0"}, 32'(cycle_count), 32'd0);
    k = 0;
    while (cpu_reset && k < 20) begin
      tick();
      k++;
    end
    check({tag, "_rstlen"}, 32'(k), 32'd2);
    k     = 1;
    ended = 1'b0;
    while (!ended && k <= 400) begin
      cpu_done = (k == done_at);
      start    = poke && (k == 3);
      prog_sel = (poke && (k == 3)) ? 2'd3 : ps;
      if (!hold_pc) cpu_pc = cpu_pc + 8'd1;
      tick();
      cpu_done = 1'b0;
      start    = 1'b0;
      if (!busy) ended = 1'b1;
      k++;
    end
    check({tag, "_ended"}, 32'(ended), 32'd1);
    x = sb.pop_front();
    check({tag, "_finished"}, 32'(finished), 32'(x.fin));
    check({tag, "_timed_out"}, 32'(timed_out), 32'(x.to));
    check({tag, "_hung"}, 32'(hung), 32'(x.hung));
    check({tag, "_cycle_count"}, 32'(cycle_count), 32'(x.cc));
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(x.crst));
    check({tag, "_prog_sel_q"}, 32'(prog_sel_q), 32'(x.ps));
  endtask

  initial begin
    int k;
    reset    = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    cpu_done = 1'b0;
    prog_sel = 2'd0;
    cpu_pc   = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    tick();

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_finished", 32'(finished), 32'd0);
    check("rst_timed_out", 32'(timed_out), 32'd0);
    check("rst_hung", 32'(hung), 32'd0);
    check("rst_cycle_count", 32'(cycle_count), 32'd0);
    check("rst_prog_sel_q", 32'(prog_sel_q), 32'd0);

    // Done on RUN cycle 37.
    run_case("done37", 2'd1, 37, 1'b0, 1'b0, '{fin: 1'b1, to: 1'b0, hung: 1'b0, cc: 16'd36, crst: 1'b0, ps: 2'd1});
    check("done37_notbusy", 32'(busy), 32'd0);

    // Abort in DONE has no effect.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_done_fin", 32'(finished), 32'd1);
    check("abort_done_crst", 32'(cpu_reset), 32'd0);

    // Timeout after 100 RUN cycles.
    run_case("timeout", 2'd2, 0, 1'b0, 1'b0, '{fin: 1'b0, to: 1'b1, hung: 1'b0, cc: 16'd100, crst: 1'b1, ps: 2'd2});

    // Done coincides with the timeout condition: done wins.
    run_case("done_vs_to", 2'd0, 100, 1'b0, 1'b0, '{fin: 1'b1, to: 1'b0, hung: 1'b0, cc: 16'd99, crst: 1'b0, ps: 2'd0});

    // Abort together with start once 10 RUN cycles have elapsed.
    prog_sel = 2'd2;
    start    = 1'b1;
    tick();
    start = 1'b0;
    k     = 0;
    while (cycle_count != 16'd10 && k < 50) begin
      cpu_pc = cpu_pc + 8'd1;
      tick();
      k++;
    end
    check("abort_reach10", 32'(cycle_count), 32'd10);
    abort    = 1'b1;
    start    = 1'b1;
    prog_sel = 2'd0;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cpu_reset", 32'(cpu_reset), 32'd1);
    check("abort_cycle_count", 32'(cycle_count), 32'd10);
    check("abort_prog_sel_q", 32'(prog_sel_q), 32'd2);
    check("abort_finished", 32'(finished), 32'd0);

    // Abort while IDLE has no effect.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle_busy", 32'(busy), 32'd0);
    check("abort_idle_cc", 32'(cycle_count), 32'd10);

    // Restart; a start pulse mid-run is ignored.
    run_case("restart", 2'd1, 5, 1'b0, 1'b1, '{fin: 1'b1, to: 1'b0, hung: 1'b0, cc: 16'd4, crst: 1'b0, ps: 2'd1});

    // Held PC: hang detection ends the run only when built in.
    cpu_pc = 8'h1A;
`ifdef HANG_DETECT_EN
    run_case("hang", 2'd2, 20, 1'b1, 1'b0, '{fin: 1'b0, to: 1'b1, hung: 1'b1, cc: 16'd8, crst: 1'b1, ps: 2'd2});
`else
    run_case("hang", 2'd2, 20, 1'b1, 1'b0, '{fin: 1'b1, to: 1'b0, hung: 1'b0, cc: 16'd19, crst: 1'b0, ps: 2'd2});
`endif

    // Reset mid-run returns everything to reset values.
    prog_sel = 2'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cpu_pc = cpu_pc + 8'd1;
      tick();
    end
    check("midrun_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("midrst_cycle_count", 32'(cycle_count), 32'd0);
    check("midrst_prog_sel_q", 32'(prog_sel_q), 32'd0);

    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
